// File: rtl/sseg_scan_monitor_if.sv
// Bundle between a multiplexed seven-segment driver and the scan monitor.
// The driver side sources en/an/ca; the monitor returns the decoded frame and tracker state.
interface sseg_scan_monitor_if;
    logic        en;
    logic [7:0]  an;
    logic [6:0]  ca;
    logic [55:0] frame_seg;
    logic        frame_valid;
    logic [3:0]  pos;
    logic        pos_valid;
    logic        moved;
    logic        dir_cw;
    logic        jump_err;
    logic        bad_frame;

    modport master (
        output en, an, ca,
        input  frame_seg, frame_valid, pos, pos_valid, moved, dir_cw, jump_err, bad_frame
    );

    modport slave (
        input  en, an, ca,
        output frame_seg, frame_valid, pos, pos_valid, moved, dir_cw, jump_err, bad_frame
    );
endinterface

// File: rtl/sseg_scan_monitor.sv
// Samples active-low anode/cathode scan lines, rebuilds 8-digit frames and
// tracks the rotating square's position and direction.
module sseg_scan_monitor #(
    parameter int STABLE  = 4,
    parameter int TIMEOUT = 65536
) (
    input logic             clk,
    input logic             rst,
    sseg_scan_monitor_if.slave bus
);
    localparam int SW = $clog2(STABLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [6:0] SEG_TOP = 7'b1100011;
    localparam logic [6:0] SEG_BOT = 7'b1011100;

    logic [7:0]    r_an;
    logic [6:0]    r_ca;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_nxt;
    logic [6:0]    slot [8];
    logic [7:0]    seen;
    logic [TW-1:0] tcnt;

    logic [55:0]   frame_seg_q;
    logic          frame_valid_q;
    logic [3:0]    pos_q;
    logic          pos_valid_q;
    logic          moved_q;
    logic          dir_cw_q;
    logic          jump_err_q;
    logic          bad_frame_q;

    logic          changed;
    logic          cap;
    logic [2:0]    cap_idx;
    logic          done;
    logic          tmo;
    logic [3:0]    nsq;
    logic          unk;
    logic [3:0]    newp;
    logic          frame_ok;

    // stab_cnt describes the pair being loaded into r_an/r_ca on this edge
    always_comb begin
        changed  = {bus.an, bus.ca} != {r_an, r_ca};
        stab_nxt = stab_cnt;
        if (changed)
            stab_nxt = SW'(1);
        else if (stab_cnt != SW'(STABLE))
            stab_nxt = stab_cnt + 1'b1;

        cap_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (!bus.an[i]) cap_idx = 3'(i);

        cap  = bus.en && $onehot(~bus.an) && (stab_nxt == SW'(STABLE))
               && (changed || stab_cnt != SW'(STABLE));
        done = (seen == 8'hFF);
        tmo  = (seen != 8'h00) && (tcnt == TW'(TIMEOUT - 1)) && !done;
    end

    always_comb begin
        nsq  = 4'd0;
        unk  = 1'b0;
        newp = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (slot[i] == SEG_TOP) begin
                nsq  = nsq + 4'd1;
                newp = 4'(i);
            end else if (slot[i] == SEG_BOT) begin
                nsq  = nsq + 4'd1;
                newp = 4'(15 - i);
            end else if (slot[i] != 7'd0) begin
                unk = 1'b1;
            end
        end
        frame_ok = (nsq == 4'd1) && !unk;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an          <= 8'hFF;
            r_ca          <= 7'h7F;
            stab_cnt      <= '0;
            seen          <= 8'h00;
            tcnt          <= '0;
            for (int i = 0; i < 8; i++) slot[i] <= 7'd0;
            frame_seg_q   <= 56'd0;
            frame_valid_q <= 1'b0;
            pos_q         <= 4'd0;
            pos_valid_q   <= 1'b0;
            moved_q       <= 1'b0;
            dir_cw_q      <= 1'b0;
            jump_err_q    <= 1'b0;
            bad_frame_q   <= 1'b0;
        end else begin
            r_an          <= bus.an;
            r_ca          <= bus.ca;
            frame_valid_q <= 1'b0;
            moved_q       <= 1'b0;
            jump_err_q    <= 1'b0;
            bad_frame_q   <= 1'b0;
            if (!bus.en) begin
                stab_cnt <= '0;
                seen     <= 8'h00;
                tcnt     <= '0;
            end else begin
                stab_cnt <= stab_nxt;
                if (cap) slot[cap_idx] <= ~bus.ca;
                if (done) begin
                    for (int i = 0; i < 8; i++) frame_seg_q[7*i +: 7] <= slot[i];
                    frame_valid_q <= 1'b1;
                    seen          <= cap ? (8'h01 << cap_idx) : 8'h00;
                    tcnt          <= '0;
                    if (!frame_ok) begin
                        bad_frame_q <= 1'b1;
                    end else if (!pos_valid_q) begin
                        pos_q       <= newp;
                        pos_valid_q <= 1'b1;
                    end else if (newp == 4'(pos_q + 4'd1)) begin
                        pos_q    <= newp;
                        moved_q  <= 1'b1;
                        dir_cw_q <= 1'b1;
                    end else if (newp == 4'(pos_q - 4'd1)) begin
                        pos_q    <= newp;
                        moved_q  <= 1'b1;
                        dir_cw_q <= 1'b0;
                    end else if (newp != pos_q) begin
                        pos_q      <= newp;
                        jump_err_q <= 1'b1;
                    end
                end else if (tmo) begin
                    seen        <= 8'h00;
                    tcnt        <= '0;
                    bad_frame_q <= 1'b1;
                end else begin
                    if (cap) seen <= seen | (8'h01 << cap_idx);
                    tcnt <= (seen != 8'h00) ? tcnt + 1'b1 : '0;
                end
            end
        end
    end

    assign bus.frame_seg   = frame_seg_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pos         = pos_q;
    assign bus.pos_valid   = pos_valid_q;
    assign bus.moved       = moved_q;
    assign bus.dir_cw      = dir_cw_q;
    assign bus.jump_err    = jump_err_q;
    assign bus.bad_frame   = bad_frame_q;
endmodule

// File: tb/tb_sseg_scan_monitor.sv
// Scoreboard bench: each driven frame or expected timeout queues a record that
// the output monitor pops and compares, including the exact event cycle.
module tb_sseg_scan_monitor;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 48;

    localparam logic [6:0] CA_BLANK = 7'b1111111;
    localparam logic [6:0] CA_TOP   = 7'b0011100;
    localparam logic [6:0] CA_BOT   = 7'b0100011;

    typedef struct {
        logic [55:0] seg;
        logic        fv;
        logic        bad;
        logic        mv;
        logic        jmp;
        logic        dir;
        logic        pv;
        logic [3:0]  pos;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];

    logic [3:0]  m_pos;
    logic        m_pv;
    logic        m_dir;
    logic [55:0] m_seg;

    sseg_scan_monitor_if bus ();

    sseg_scan_monitor #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.frame_valid || bus.bad_frame) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 64'(cyc), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("frame_valid", 64'(bus.frame_valid), 64'(e.fv));
                chk("bad_frame",   64'(bus.bad_frame),   64'(e.bad));
                chk("moved",       64'(bus.moved),       64'(e.mv));
                chk("jump_err",    64'(bus.jump_err),    64'(e.jmp));
                chk("dir_cw",      64'(bus.dir_cw),      64'(e.dir));
                chk("pos",         64'(bus.pos),         64'(e.pos));
                chk("pos_valid",   64'(bus.pos_valid),   64'(e.pv));
                chk("frame_seg",   64'(bus.frame_seg),   64'(e.seg));
            end
        end
        if ((bus.moved || bus.jump_err) && !bus.frame_valid)
            chk("stray_pulse", 64'({bus.moved, bus.jump_err}), 64'(0));
    end

    task automatic hold(input logic [7:0] a, input logic [6:0] c, input int n);
        bus.an = a;
        bus.ca = c;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] an_of(input int d);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << d);
    endfunction

    // Expected outcome of a completed frame from the behavioural tracker model
    task automatic push_frame(input logic [55:0] cas, input int ecyc);
        exp_t e;
        int   nsq;
        bit   unk;
        int   p;
        logic [6:0] c;
        nsq = 0; unk = 0; p = 0;
        e.seg = '0; e.mv = 0; e.jmp = 0; e.bad = 0; e.fv = 1;
        for (int d = 0; d < 8; d++) begin
            c = cas[7*d +: 7];
            e.seg[7*d +: 7] = ~c;
            if (c == CA_TOP) begin nsq++; p = d; end
            else if (c == CA_BOT) begin nsq++; p = 15 - d; end
            else if (c != CA_BLANK) unk = 1;
        end
        if (nsq != 1 || unk) begin
            e.bad = 1;
        end else if (!m_pv) begin
            m_pos = 4'(p);
            m_pv  = 1;
        end else if (p != int'(m_pos)) begin
            if (p == (int'(m_pos) + 1) % 16) begin e.mv = 1; m_dir = 1; end
            else if (p == (int'(m_pos) + 15) % 16) begin e.mv = 1; m_dir = 0; end
            else e.jmp = 1;
            m_pos = 4'(p);
        end
        m_seg = e.seg;
        e.pos = m_pos; e.pv = m_pv; e.dir = m_dir; e.cyc = ecyc;
        sb.push_back(e);
    endtask

    task automatic push_timeout(input int first_drive_cyc);
        exp_t e;
        e.seg = m_seg; e.fv = 0; e.bad = 1; e.mv = 0; e.jmp = 0;
        e.dir = m_dir; e.pv = m_pv; e.pos = m_pos;
        e.cyc = first_drive_cyc + STABLE + TIMEOUT;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [55:0] cas, input int dw);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push_frame(cas, cyc + STABLE + 1);
            hold(an_of(i), cas[7*i +: 7], dw);
        end
    endtask

    task automatic send_digits(input logic [55:0] cas, input int lo, input int hi,
                               input int dw, output int first_cyc);
        first_cyc = cyc;
        for (int i = lo; i <= hi; i++) hold(an_of(i), cas[7*i +: 7], dw);
    endtask

    function automatic logic [55:0] frame_with(input int d, input logic [6:0] c);
        logic [55:0] f;
        f = {8{CA_BLANK}};
        f[7*d +: 7] = c;
        return f;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"},   64'(bus.frame_seg), 64'(0));
        chk({tag, "_pos"},   64'(bus.pos), 64'(0));
        chk({tag, "_pv"},    64'(bus.pos_valid), 64'(0));
        chk({tag, "_dir"},   64'(bus.dir_cw), 64'(0));
        chk({tag, "_pulse"}, 64'({bus.frame_valid, bus.moved, bus.jump_err, bus.bad_frame}), 64'(0));
    endtask

    initial begin
        int fc;
        logic [55:0] f;
        m_pos = 0; m_pv = 0; m_dir = 0; m_seg = 0;
        rst = 1'b0; bus.en = 1'b0; bus.an = 8'hFF; bus.ca = 7'h7F;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1; bus.en = 1'b1;
        hold(8'hFF, 7'h7F, 4);

        // 3-cycle glitch on digit 0 must not count: digits 1..7 then time out
        hold(8'hFE, 7'h7F, 3);
        send_digits({8{CA_BLANK}}, 1, 7, 5, fc);
        push_timeout(fc);
        hold(8'hFF, 7'h7F, TIMEOUT + 10);

        // clockwise sweep; first frame uses the minimum dwell
        send_frame(frame_with(0, CA_TOP), 4);
        hold(8'hFF, 7'h7F, 3);
        send_frame(frame_with(1, CA_TOP), 5);
        send_frame(frame_with(0, CA_TOP), 5);
        send_frame(frame_with(0, CA_BOT), 5);
        send_frame(frame_with(7, CA_BOT), 5);
        send_frame(frame_with(7, CA_BOT), 5);
        send_frame(frame_with(0, CA_BOT), 5);
        send_frame(frame_with(0, CA_TOP), 6);
        hold(8'hFF, 7'h7F, 3);

        send_frame({8{CA_BLANK}}, 5);
        f = frame_with(2, CA_TOP);
        f[7*5 +: 7] = CA_BOT;
        send_frame(f, 5);
        send_frame(frame_with(3, 7'h00), 5);
        hold(8'hFF, 7'h7F, 3);

        // en drop mid-frame discards digits 0..4
        send_digits(frame_with(1, CA_TOP), 0, 4, 5, fc);
        bus.en = 1'b0;
        hold(8'hFF, 7'h7F, 4);
        bus.en = 1'b1;
        send_digits(frame_with(1, CA_TOP), 5, 7, 5, fc);
        push_timeout(fc);
        hold(8'hFF, 7'h7F, TIMEOUT + 10);
        send_frame(frame_with(1, CA_TOP), 5);
        hold(8'hFF, 7'h7F, 3);

        // synchronous reset mid-frame
        send_digits(frame_with(2, CA_TOP), 0, 3, 5, fc);
        rst = 1'b0;
        m_pos = 0; m_pv = 0; m_dir = 0; m_seg = 0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst = 1'b1;
        send_digits(frame_with(2, CA_TOP), 4, 7, 5, fc);
        push_timeout(fc);
        hold(8'hFF, 7'h7F, TIMEOUT + 10);
        send_frame(frame_with(3, CA_TOP), 5);
        hold(8'hFF, 7'h7F, 10);

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sseg_scan_monitor.md
# sseg_scan_monitor

Receiving end of the multiplexed seven-segment interface: samples the active-low anode (AN) and cathode (CA) lines driven by the rotating-square display driver, de-glitches and de-multiplexes them into per-digit segment patterns, and reconstructs the square's position and rotation direction. It sits beside the display driver as a self-check and loopback monitor, and as a bench-side scoreboard for display-driver verification.

## Interface
- STABLE, 4: consecutive cycles an (AN, CA) pair must hold before capture (≥1)
- TIMEOUT, 65536: max cycles allowed to complete one scan frame
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low
- en  in  1  monitor enable
- AN  in  8  digit anodes, active-low; AN[i] selects digit i
- CA  in  7  segment cathodes, active-low; CA[0]=a … CA[6]=g
- frame_seg  out  56  last completed frame, active-high segments; digit i at [7i+6:7i]
- frame_valid  out  1  one-cycle pulse per completed frame
- pos  out  4  square position 0..15
- pos_valid  out  1  level; pos holds a decoded position
- moved  out  1  one-cycle pulse on a ±1 position step
- dir_cw  out  1  direction of the last step (1 = pos increment)
- jump_err  out  1  one-cycle pulse on a non-adjacent position change
- bad_frame  out  1  one-cycle pulse on an unclassifiable frame or timeout

## Operation
- Input stage: AN and CA are registered once (r_an, r_ca). stab_cnt resets to 1 when the registered pair differs from the previous registered pair; otherwise it increments, saturating at STABLE.
- Capture: a pair is captured once per stable run, on the cycle stab_cnt reaches STABLE, and only if r_an has exactly one zero bit. Captured ~r_ca is written to slot i, and seen[i] is set. Recapturing digit i within a frame overwrites slot i.
- Frame completion: when seen becomes 8'hFF, on the next edge all slots copy to frame_seg, frame_valid pulses, seen clears, and the frame is classified.
- Pattern classes (CA value): blank 7'b1111111; top square 7'b0011100 (a,b,f,g lit); bottom square 7'b0100011 (c,d,e,g lit). Any other value is unknown.
- Position map: top square on digit d gives pos = d. Bottom square on digit d gives pos = 15 − d. Clockwise means pos increments mod 16.
- Valid frame: exactly one square and seven blanks.
  - Any other frame (all blank, two or more squares, any unknown pattern) pulses bad_frame. pos and pos_valid are unchanged.
- Tracker, on a valid frame with new position p:
  - If pos_valid = 0: pos ← p, pos_valid ← 1, no moved pulse.
  - p = pos: no action.
  - p = pos+1 mod 16: moved, dir_cw ← 1.
  - p = pos−1 mod 16: moved, dir_cw ← 0.
  - Otherwise: jump_err pulses, dir_cw is unchanged, and pos ← p in every case.
- Timeout: tcnt counts cycles while seen ≠ 0. When it reaches TIMEOUT: seen and tcnt clear, bad_frame pulses, frame_seg is not updated.
- en = 0: stab_cnt held at 0, seen and tcnt cleared, no captures. All outputs hold; pulses are 0.

## Timing
- Reset (rst = 0 at an edge): frame_seg = 0, pos = 0, pos_valid = 0, dir_cw = 0, all pulses 0. Internal registers clear: slots, seen, stab_cnt, tcnt.
- Latency: a pair first present at edge k is registered at k, captured at edge k+STABLE−1, and frame outputs appear at edge k+STABLE if that capture completes the frame.
- moved, jump_err and bad_frame (classification) assert in the same cycle as frame_valid.
- Simultaneous events:
  - Completion and timeout in the same cycle: completion wins.
  - en falling on the completion cycle: the frame is discarded.
  - Reset mid-frame: the partial frame is discarded.
- A pair shorter than STABLE cycles is never captured (glitch rejection).
- AN all-ones or multi-zero: never captured; stability counting continues.

## Test plan
- Glitch rejection (STABLE=4): hold AN=8'hFE, CA=7'h7F for 3 cycles, then change → seen stays 0; hold 4 cycles → slot 0 captured.
- Clockwise sweep (STABLE=2): scan frames with the top square on digit 0, then digit 1 → first frame: pos=0, pos_valid=1, no moved; second frame: moved pulse, pos=1, dir_cw=1.
- Wrap-around: frame with the top square on digit 0, then bottom square on digit 0 → pos 0→15, moved, dir_cw=0. Next frame with bottom square on digit 7 (pos 8) → jump_err, pos=8.
- Bad frames: all-blank frame, then a two-square frame, then CA=7'h00 on digit 3 → three bad_frame pulses; pos and pos_valid unchanged; frame_seg updated each time.
- Timeout (TIMEOUT=16): capture digits 0..6 only, then idle → bad_frame exactly 16 cycles after the first capture; seen=0.
- en/reset mid-frame: drop en after 5 digits, then restore → the next complete 8-digit scan produces exactly one frame_valid. rst=0 mid-frame → all outputs at reset values the next cycle.
